// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// Request fields are registered by the master and held until ack.
// Slave completes a request by raising ack for one cycle; rdata is valid with ack on reads.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Purpose: MEM pipeline stage; loads/stores over a req/ack bus, branch redirect, MEM/WB register.
// Latency: non-memory op 1 cycle to wb_*; memory op req 1 cycle after accept, wb_* on edge after ack.
// Backpressure: mem_stall holds upstream while an access is pending; MEM_MISALIGN_TRAP_EN enables traps.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_branch,
    input  logic        ex_zero,
    input  logic [31:0] ex_branch_target,
    output logic        mem_stall,
    output logic        npc_control,
    output logic [31:0] branch_pc,
    mem_stage_if.master dmem,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        misalign_trap
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // funct3[1:0] encodes access size (00 byte, 01 half, else word); funct3[2] means unsigned
    logic [1:0]  size;
    logic        is_mem;
    logic        trap_take;
    logic        start_cond;
    logic [1:0]  lane;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;

    // context of the access in flight, captured when the request is issued
    logic [4:0]  acc_rd;
    logic        acc_reg_write;
    logic        acc_load;
    logic [2:0]  acc_funct3;
    logic [1:0]  acc_lane;
    logic [31:0] acc_result;
    logic [31:0] rdata_shifted;
    logic [31:0] load_data;

    assign size   = ex_funct3[1:0];
    assign is_mem = ex_mem_read | ex_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((size == 2'b01) & ex_alu_result[0]) |
                        (size[1] & (ex_alu_result[1:0] != 2'b00));
    assign trap_take  = ex_valid & is_mem & misaligned;
`else
    assign trap_take  = 1'b0;
`endif

    assign start_cond = ex_valid & is_mem & ~trap_take;

    // Lane offset and byte-lane encoding; offsets are forced to natural alignment
    always_comb begin
        lane      = 2'b00;
        be_nxt    = 4'b1111;
        wdata_nxt = ex_store_data;
        case (size)
            2'b00: begin
                lane      = ex_alu_result[1:0];
                be_nxt    = 4'b0001 << ex_alu_result[1:0];
                wdata_nxt = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                lane      = {ex_alu_result[1], 1'b0};
                be_nxt    = 4'b0011 << {ex_alu_result[1], 1'b0};
                wdata_nxt = {2{ex_store_data[15:0]}};
            end
            default: begin
                lane      = 2'b00;
                be_nxt    = 4'b1111;
                wdata_nxt = ex_store_data;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state: enter ACCESS on an accepted memory op, leave on ack
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_cond) state_nxt = ACCESS;
            ACCESS:  if (dmem.ack)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM output: stall while a memory op waits to issue or waits for ack
    always_comb begin
        mem_stall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    mem_stall = start_cond;
                ACCESS:  mem_stall = ~dmem.ack;
                default: mem_stall = 1'b0;
            endcase
        end
    end

    // Request register: load on issue, hold through ACCESS, drop on ack
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.addr  <= 32'h0;
            dmem.wdata <= 32'h0;
            dmem.be    <= 4'h0;
        end else if (state == IDLE && start_cond) begin
            dmem.req   <= 1'b1;
            dmem.we    <= ex_mem_write;
            dmem.addr  <= {ex_alu_result[31:2], 2'b00};
            dmem.wdata <= wdata_nxt;
            dmem.be    <= be_nxt;
        end else if (state == ACCESS && dmem.ack) begin
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
        end
    end

    // Capture the in-flight access context so write-back does not depend on upstream holding
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_rd        <= 5'd0;
            acc_reg_write <= 1'b0;
            acc_load      <= 1'b0;
            acc_funct3    <= 3'd0;
            acc_lane      <= 2'd0;
            acc_result    <= 32'h0;
        end else if (state == IDLE && start_cond) begin
            acc_rd        <= ex_rd;
            acc_reg_write <= ex_reg_write & ex_mem_read;
            acc_load      <= ex_mem_read;
            acc_funct3    <= ex_funct3;
            acc_lane      <= lane;
            acc_result    <= ex_alu_result;
        end
    end

    // Load extract: shift the addressed lane down, then sign/zero extend by funct3
    always_comb begin
        rdata_shifted = dmem.rdata >> {acc_lane, 3'b000};
        case (acc_funct3)
            3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b100:  load_data = {24'h0, rdata_shifted[7:0]};
            3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b101:  load_data = {16'h0, rdata_shifted[15:0]};
            default: load_data = rdata_shifted;
        endcase
    end

    // MEM/WB register: ALU ops and traps in IDLE, memory results on the ack edge, bubbles otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_reg_write <= 1'b0;
            wb_data      <= 32'h0;
        end else if (state == ACCESS) begin
            if (dmem.ack) begin
                wb_valid     <= 1'b1;
                wb_rd        <= acc_rd;
                wb_reg_write <= acc_reg_write;
                wb_data      <= acc_load ? load_data : acc_result;
            end else begin
                wb_valid     <= 1'b0;
                wb_reg_write <= 1'b0;
            end
        end else if (ex_valid && !start_cond) begin
            wb_valid     <= 1'b1;
            wb_rd        <= ex_rd;
            wb_reg_write <= ex_reg_write & ~trap_take;
            wb_data      <= ex_alu_result;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
        end
    end

    // Branch redirect: one-cycle pulse, target held between redirects
    always_ff @(posedge clk) begin
        if (rst) begin
            npc_control <= 1'b0;
            branch_pc   <= 32'h0;
        end else begin
            npc_control <= (state == IDLE) & ex_valid & ex_branch & ex_zero;
            if (state == IDLE && ex_valid && ex_branch && ex_zero)
                branch_pc <= ex_branch_target;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned-access pulse, raised alongside the non-writing wb slot
    always_ff @(posedge clk) begin
        if (rst) misalign_trap <= 1'b0;
        else     misalign_trap <= (state == IDLE) & trap_take;
    end
`else
    assign misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, random ops against a byte-lane model, reset-abort sequence.
// Drives inputs 1ns after the rising edge and samples outputs at that point or 1ns later.
// The bench plays the data memory, returning ack after a per-op delay.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic        ex_branch;
    logic        ex_zero;
    logic [31:0] ex_branch_target;
    logic        mem_stall;
    logic        npc_control;
    logic [31:0] branch_pc;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        misalign_trap;

    mem_stage_if dmem_bus ();

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_alu_result    (ex_alu_result),
        .ex_store_data    (ex_store_data),
        .ex_rd            (ex_rd),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_funct3        (ex_funct3),
        .ex_branch        (ex_branch),
        .ex_zero          (ex_zero),
        .ex_branch_target (ex_branch_target),
        .mem_stall        (mem_stall),
        .npc_control      (npc_control),
        .branch_pc        (branch_pc),
        .dmem             (dmem_bus),
        .wb_valid         (wb_valid),
        .wb_rd            (wb_rd),
        .wb_reg_write     (wb_reg_write),
        .wb_data          (wb_data),
        .misalign_trap    (misalign_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd_op;
        logic        wr_op;
        logic        br;
        logic        zero;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [31:0] target;
        logic [4:0]  rd;
        logic        regw;
        int          delay;
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_npc;
    } vec_t;

    int compared;
    int mismatched;
    logic [31:0] last_bpc;
    bit trap_build;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: an access of n bytes sits at the byte offset rounded down to a multiple of n
    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int offset_of(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        n = nbytes(f3);
        return ((int'(addr % 4)) / n) * n;
    endfunction

    function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        return (int'(addr % 4) % nbytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        longint val;
        longint span;
        int n;
        n    = nbytes(f3);
        span = longint'(1) << (8 * n);
        val  = (longint'(rdata) >> (8 * offset_of(f3, addr))) % span;
        if (!f3[2] && n < 4 && val >= span / 2) val = val - span;
        return val[31:0];
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int m;
        m = ((1 << nbytes(f3)) - 1) << offset_of(f3, addr);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sdata);
        logic [31:0] w;
        int n;
        n = nbytes(f3);
        w = 32'h0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sdata[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic vec_t mk(input logic rd_op, input logic wr_op, input logic br, input logic zero,
                                input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] rdata, input logic [31:0] target, input logic [4:0] rd,
                                input logic regw, input int delay, input logic [31:0] exp_data,
                                input logic [3:0] exp_be, input logic [31:0] exp_wdata, input logic exp_npc);
        vec_t v;
        v.rd_op = rd_op; v.wr_op = wr_op; v.br = br; v.zero = zero; v.f3 = f3;
        v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.target = target; v.rd = rd;
        v.regw = regw; v.delay = delay; v.exp_data = exp_data; v.exp_be = exp_be;
        v.exp_wdata = exp_wdata; v.exp_npc = exp_npc;
        return v;
    endfunction

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_alu_result = 32'h0; ex_store_data = 32'h0; ex_rd = 5'd0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = 3'd0;
        ex_branch = 1'b0; ex_zero = 1'b0; ex_branch_target = 32'h0;
    endtask

    // Present one instruction, act as memory for it, check stall/request/write-back/redirect
    task automatic exec_op(input vec_t v);
        bit mem;
        bit trap;
        mem  = v.rd_op | v.wr_op;
        trap = trap_build && mem && is_misaligned(v.f3, v.addr);
        ex_valid = 1'b1; ex_alu_result = v.addr; ex_store_data = v.sdata; ex_rd = v.rd;
        ex_reg_write = v.regw; ex_mem_read = v.rd_op; ex_mem_write = v.wr_op; ex_funct3 = v.f3;
        ex_branch = v.br; ex_zero = v.zero; ex_branch_target = v.target;
        #1;
        chk("stall_on_accept", 32'(mem_stall), 32'(mem && !trap));
        @(posedge clk); #1;
        if (mem && !trap) begin
            chk("req_issued", 32'(dmem_bus.req), 32'd1);
            chk("req_we", 32'(dmem_bus.we), 32'(v.wr_op));
            chk("req_addr", dmem_bus.addr, {v.addr[31:2], 2'b00});
            if (v.wr_op) begin
                chk("store_be", 32'(dmem_bus.be), 32'(v.exp_be));
                chk("store_wdata", dmem_bus.wdata, v.exp_wdata);
            end
            chk("wb_bubble_at_req", 32'(wb_valid), 32'd0);
            for (int c = 0; c <= v.delay; c++) begin
                if (c == v.delay) begin
                    dmem_bus.ack = 1'b1; dmem_bus.rdata = v.rdata;
                end else begin
                    dmem_bus.rdata = $urandom;
                end
                #1;
                chk("stall_during_access", 32'(mem_stall), 32'(c != v.delay));
                chk("req_held", 32'(dmem_bus.req), 32'd1);
                chk("addr_held", dmem_bus.addr, {v.addr[31:2], 2'b00});
                @(posedge clk); #1;
                dmem_bus.ack = 1'b0;
                if (c != v.delay) chk("wb_bubble_waiting", 32'(wb_valid), 32'd0);
            end
            chk("req_dropped", 32'(dmem_bus.req), 32'd0);
            chk("wb_valid_mem", 32'(wb_valid), 32'd1);
            chk("wb_rd_mem", 32'(wb_rd), 32'(v.rd));
            chk("wb_reg_write_mem", 32'(wb_reg_write), 32'(v.rd_op & v.regw));
            if (v.rd_op) chk("load_data", wb_data, v.exp_data);
        end else begin
            chk("no_req", 32'(dmem_bus.req), 32'd0);
            chk("wb_valid_direct", 32'(wb_valid), 32'd1);
            chk("wb_reg_write_direct", 32'(wb_reg_write), 32'(v.regw && !trap));
            chk("misalign_trap", 32'(misalign_trap), 32'(trap));
            if (!mem) begin
                chk("wb_rd_alu", 32'(wb_rd), 32'(v.rd));
                chk("wb_data_alu", wb_data, v.addr);
                chk("npc_pulse", 32'(npc_control), 32'(v.exp_npc));
                if (v.exp_npc) last_bpc = v.target;
                chk("branch_pc", branch_pc, last_bpc);
            end
        end
        idle_inputs();
        @(posedge clk); #1;
        chk("noop_wb_valid", 32'(wb_valid), 32'd0);
        chk("noop_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("npc_single_cycle", 32'(npc_control), 32'd0);
        chk("trap_single_cycle", 32'(misalign_trap), 32'd0);
    endtask

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int kind;
        logic [2:0] load_f3s [5];
        compared = 0;
        mismatched = 0;
        last_bpc = 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap_build = 1'b1;
`else
        trap_build = 1'b0;
`endif
        load_f3s[0] = 3'b000; load_f3s[1] = 3'b001; load_f3s[2] = 3'b010;
        load_f3s[3] = 3'b100; load_f3s[4] = 3'b101;

        //          rd wr br z  f3      addr          sdata         rdata         target        rd  rw dly exp_data      be       wdata         npc
        vecs[0]  = mk(1, 0, 0, 0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 32'h0,        5,  1, 2,  32'hDEADBEEF, 4'hF,    32'h0,        0);
        vecs[1]  = mk(1, 0, 0, 0, 3'b000, 32'h13,       32'h0,        32'h80123456, 32'h0,        6,  1, 0,  32'hFFFFFF80, 4'h0,    32'h0,        0);
        vecs[2]  = mk(1, 0, 0, 0, 3'b100, 32'h13,       32'h0,        32'h80123456, 32'h0,        6,  1, 1,  32'h00000080, 4'h0,    32'h0,        0);
        vecs[3]  = mk(1, 0, 0, 0, 3'b001, 32'h12,       32'h0,        32'h80123456, 32'h0,        8,  1, 0,  32'hFFFF8012, 4'h0,    32'h0,        0);
        vecs[4]  = mk(1, 0, 0, 0, 3'b101, 32'h12,       32'h0,        32'h80123456, 32'h0,        8,  1, 3,  32'h00008012, 4'h0,    32'h0,        0);
        vecs[5]  = mk(0, 1, 0, 0, 3'b000, 32'h12,       32'h000000AB, 32'h0,        32'h0,        9,  0, 1,  32'h0,        4'b0100, 32'hABABABAB, 0);
        vecs[6]  = mk(0, 1, 0, 0, 3'b001, 32'h16,       32'h1234CDEF, 32'h0,        32'h0,        9,  0, 0,  32'h0,        4'b1100, 32'hCDEFCDEF, 0);
        vecs[7]  = mk(0, 1, 0, 0, 3'b010, 32'h18,       32'hCAFEF00D, 32'h0,        32'h0,        9,  0, 2,  32'h0,        4'b1111, 32'hCAFEF00D, 0);
        vecs[8]  = mk(0, 0, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        32'h40,       0,  0, 0,  32'h0,        4'h0,    32'h0,        1);
        vecs[9]  = mk(0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h80,       0,  0, 0,  32'h0,        4'h0,    32'h0,        0);
        vecs[10] = mk(0, 0, 0, 0, 3'b000, 32'h1234,     32'h0,        32'h0,        32'h0,        7,  1, 0,  32'h0,        4'h0,    32'h0,        0);
        vecs[11] = mk(1, 0, 0, 0, 3'b010, 32'h22,       32'h0,        32'h11223344, 32'h0,        10, 1, 1,  32'h11223344, 4'h0,    32'h0,        0);
        vecs[12] = mk(1, 0, 0, 0, 3'b000, 32'h11,       32'h0,        32'h00007F00, 32'h0,        11, 1, 0,  32'h0000007F, 4'h0,    32'h0,        0);
        vecs[13] = mk(1, 0, 0, 0, 3'b001, 32'h11,       32'h0,        32'hAAAA8001, 32'h0,        12, 1, 0,  32'hFFFF8001, 4'h0,    32'h0,        0);

        idle_inputs();
        dmem_bus.ack = 1'b0;
        dmem_bus.rdata = 32'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_npc", 32'(npc_control), 32'd0);
        chk("rst_branch_pc", branch_pc, 32'd0);
        chk("rst_req", 32'(dmem_bus.req), 32'd0);
        chk("rst_we", 32'(dmem_bus.we), 32'd0);
        chk("rst_addr", dmem_bus.addr, 32'd0);
        chk("rst_wdata", dmem_bus.wdata, 32'd0);
        chk("rst_be", 32'(dmem_bus.be), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_trap", 32'(misalign_trap), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) exec_op(vecs[i]);

        // Reset aborts an outstanding access; a late ack must not produce a write-back
        v = mk(1, 0, 0, 0, 3'b010, 32'h30, 32'h0, 32'h0, 32'h0, 13, 1, 0, 32'h0, 4'h0, 32'h0, 0);
        ex_valid = 1'b1; ex_alu_result = v.addr; ex_rd = v.rd; ex_reg_write = 1'b1;
        ex_mem_read = 1'b1; ex_funct3 = v.f3;
        @(posedge clk); #1;
        chk("abort_req_before", 32'(dmem_bus.req), 32'd1);
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        chk("abort_req", 32'(dmem_bus.req), 32'd0);
        chk("abort_stall", 32'(mem_stall), 32'd0);
        chk("abort_wb_valid", 32'(wb_valid), 32'd0);
        rst = 1'b0;
        last_bpc = 32'h0;
        dmem_bus.ack = 1'b1;
        dmem_bus.rdata = 32'h55AA55AA;
        #1;
        chk("late_ack_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        dmem_bus.ack = 1'b0;
        chk("late_ack_wb_valid", 32'(wb_valid), 32'd0);
        chk("late_ack_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("late_ack_req", 32'(dmem_bus.req), 32'd0);

        // Random mix of loads, stores, ALU ops and branches against the lane model
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 3));
            v = mk(0, 0, 0, 0, 3'b000, $urandom, $urandom, $urandom, $urandom & 32'hFFFFFFFC,
                   5'($urandom_range(0, 31)), 1'b0, int'($urandom_range(0, 3)), 32'h0, 4'h0, 32'h0, 0);
            case (kind)
                0: begin
                    v.rd_op = 1'b1; v.regw = 1'b1;
                    v.f3 = load_f3s[$urandom_range(0, 4)];
                    v.exp_data = model_load(v.f3, v.addr, v.rdata);
                end
                1: begin
                    v.wr_op = 1'b1;
                    v.f3 = 3'($urandom_range(0, 2));
                    v.exp_be = model_be(v.f3, v.addr);
                    v.exp_wdata = model_wdata(v.f3, v.sdata);
                end
                2: v.regw = 1'($urandom_range(0, 1));
                default: begin
                    v.br = 1'b1; v.zero = 1'($urandom_range(0, 1));
                    v.exp_npc = v.zero;
                end
            endcase
            exec_op(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
